mult_share_arbiter: RTL
=======================

Name: mult_share_arbiter

Overview:
- Clocked controller that shares one multiplier unit among N requesters, such as the PE lanes of an SNN core computing weight × spike-potential products.
- Arbitrates requester operand pairs round-robin and issues one pair at a time to the multiplier over a valid/ready handshake.
- Waits for the product, then returns it to the granted requester.
- Keeps a per-block operation counter and a watchdog error flag for hung multiplier transactions.

Parameters:
- N, 4, number of requesters (2..8).
- WIDTH, 8, operand and result width; product truncated to WIDTH bits.
- IDW, 2, width of grant index; must equal ceil(log2(N)).
- TIMEOUT, 64, max cycles in WAIT before err is raised.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N  requester i has operands pending.
- req_ready  out  N  one-hot pulse: operands of requester i accepted this cycle.
- req_a  in  N*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  N*WIDTH  operand B, same packing.
- rsp_valid  out  N  one-hot: result available for requester i.
- rsp_ready  in  N  requester i takes the result.
- rsp_data  out  WIDTH  product, shared bus, meaningful only when a rsp_valid bit is set.
- mul_valid  out  1  operand pair presented to multiplier.
- mul_ready  in  1  multiplier accepts operand pair.
- mul_a, mul_b  out  WIDTH  latched operands.
- mul_done  in  1  one-cycle pulse: product valid on mul_p.
- mul_p  in  WIDTH  multiplier product (already truncated).
- grant_id  out  IDW  index of requester currently served.
- busy  out  1  high in any state other than IDLE.
- op_count  out  16  completed operations, wraps 0xFFFF→0x0000.
- err  out  1  sticky watchdog flag, cleared only by rst.

Behaviour:
- Reset values: all outputs 0; state=IDLE; last_grant=N-1, so requester 0 has first priority; watchdog counter 0.
- Reset mid-operation: the transaction is abandoned and the product is discarded. mul_valid and rsp_valid are 0 from the cycle after rst is sampled.
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - If any req_valid is set, pick the first set bit searching (last_grant+1) mod N upward with wrap.
  - Pulse req_ready[g] combinationally in that cycle.
  - Latch req_a/req_b of g into mul_a/mul_b and g into grant_id; go to ISSUE.
  - If no req_valid is set, stay in IDLE with req_ready=0.
  - req_valid is sampled only in IDLE. A requester may drop req_valid at any time before it is granted.
- ISSUE: mul_valid=1 with mul_a/mul_b held stable. On mul_valid & mul_ready at a clock edge, go to WAIT and clear the watchdog.
- WAIT:
  - mul_valid=0; the watchdog increments each cycle.
  - On mul_done: capture mul_p into rsp_data and go to RESP.
  - If the watchdog reaches TIMEOUT: set err=1, drive rsp_data=0 and go to RESP, so the requester is never hung.
  - mul_done outside WAIT is ignored.
- RESP:
  - rsp_valid[grant_id]=1; rsp_data held stable until rsp_ready[grant_id].
  - On handshake: last_grant←grant_id, op_count+1, go to IDLE.
  - rsp_ready bits of other requesters are ignored.
- Latency: with mul_ready=1 and mul_done one cycle after acceptance, req_ready pulse at cycle T, mul_valid at T+1, mul_done at T+2, rsp_valid at T+3. With immediate rsp_ready, the next grant is possible at T+4.
- Arbiter is non-pipelined: at most one transaction is in flight.
- Fairness: with all requesters continuously valid, the grant sequence is 0,1,…,N-1,0,…
- Invariants:
  - req_ready and rsp_valid are one-hot or zero.
  - At most one of req_ready, mul_valid or rsp_valid is nonzero in any cycle.

Test Plan:
- Single op: rst then req_valid=0001, a0=6, b0=7, multiplier returns 42 one cycle after accept → req_ready=0001 at T, rsp_valid=0001 with rsp_data=42 at T+3, op_count=1.
- Round-robin: all four valid, a_i=i+1, b_i=3 → grant order 0,1,2,3,0; rsp_data 3,6,9,12,3.
- Backpressure: mul_ready low 5 cycles, rsp_ready low 4 cycles → mul_a/mul_b and rsp_data held stable, no second req_ready pulse, grant_id unchanged.
- Truncation pass-through: a=200, b=3, mul_p=0x58 → rsp_data=0x58 (600 mod 256 = 88).
- Watchdog: mul_done never asserted → err=1 at the TIMEOUT=64th WAIT cycle, rsp_valid set with rsp_data=0; err stays 1 after further ops until rst.
- Reset mid-WAIT: assert rst one cycle in WAIT, then a late mul_done → busy=0, no rsp_valid, op_count=0, next grant goes to requester 0.

Source files
------------

// File: rtl/mult_share_arbiter_if.sv
// Handshake bundle between the multiplier-sharing arbiter, its requesters and the multiplier.
// master is the arbiter's view; slave is the environment (requesters plus multiplier).
interface mult_share_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*WIDTH-1:0] req_a;
  logic [N*WIDTH-1:0] req_b;
  logic [N-1:0]       rsp_valid;
  logic [N-1:0]       rsp_ready;
  logic [WIDTH-1:0]   rsp_data;
  logic               mul_valid;
  logic               mul_ready;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_done;
  logic [WIDTH-1:0]   mul_p;

  modport master (
    input  req_valid, req_a, req_b, rsp_ready, mul_ready, mul_done, mul_p,
    output req_ready, rsp_valid, rsp_data, mul_valid, mul_a, mul_b
  );

  modport slave (
    output req_valid, req_a, req_b, rsp_ready, mul_ready, mul_done, mul_p,
    input  req_ready, rsp_valid, rsp_data, mul_valid, mul_a, mul_b
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one multiplier among N requesters, one transaction in flight,
// with a completed-operation counter and a sticky watchdog flag for hung multiplies.
//
// state   | meaning
// IDLE    | pick next requester round-robin, pulse req_ready, latch operands
// ISSUE   | present operands to multiplier until accepted
// WAIT    | await mul_done, watchdog running
// RESP    | hold product for granted requester until it takes it
module mult_share_arbiter #(
  parameter int N       = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_share_arbiter_if.master bus,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic [15:0]          op_count,
  output logic                 err
);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state, state_nx;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   pick;
  logic             pick_found;
  logic [WIDTH-1:0] mul_a_q, mul_b_q, rsp_data_q;
  logic [WDW-1:0]   wdog;
  logic             timeout_hit;

  // First valid requester after the last one served, wrapping.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!pick_found && bus.req_valid[(int'(last_grant) + k) % N]) begin
        pick_found = 1'b1;
        pick       = IDW'((int'(last_grant) + k) % N);
      end
    end
  end

  assign timeout_hit = (wdog == WDW'(TIMEOUT - 1));

  always_comb begin
    state_nx      = state;
    bus.req_ready = '0;
    bus.mul_valid = 1'b0;
    bus.rsp_valid = '0;
    case (state)
      S_IDLE: begin
        if (!rst && pick_found) begin
          bus.req_ready[pick] = 1'b1;
          state_nx            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.mul_valid = 1'b1;
        if (bus.mul_ready) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mul_done || timeout_hit) state_nx = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid[grant_id] = 1'b1;
        if (bus.rsp_ready[grant_id]) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= IDW'(N - 1);
      grant_id   <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      rsp_data_q <= '0;
      wdog       <= '0;
      op_count   <= '0;
      err        <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_id <= pick;
            mul_a_q  <= bus.req_a[int'(pick) * WIDTH +: WIDTH];
            mul_b_q  <= bus.req_b[int'(pick) * WIDTH +: WIDTH];
          end
        end
        S_ISSUE: begin
          if (bus.mul_ready) wdog <= '0;
        end
        S_WAIT: begin
          // A real product wins over a watchdog expiring in the same cycle.
          if (bus.mul_done) begin
            rsp_data_q <= bus.mul_p;
          end else if (timeout_hit) begin
            err        <= 1'b1;
            rsp_data_q <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready[grant_id]) begin
            last_grant <= grant_id;
            op_count   <= op_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mul_a    = mul_a_q;
  assign bus.mul_b    = mul_b_q;
  assign bus.rsp_data = rsp_data_q;
  assign busy         = (state != S_IDLE);
endmodule
